// File: rtl/matrix_scan.sv
// Row-multiplexed LED matrix scanner with per-frame pixel/brightness shadowing.
// Three-state FSM (IDLE/BLANK/DRIVE); every output is driven from a flop.
module matrix_scan #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int BRIGHT_BITS    = 3,
  parameter int BLANK_CYCLES   = 1,
  parameter int ROW_ACTIVE_LOW = 1,
  parameter int COL_ACTIVE_LOW = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ROWS*COLS-1:0]     pixels,
  input  logic [BRIGHT_BITS-1:0]   brightness,
  input  logic                     enable,
  output logic [ROWS-1:0]          row_pins,
  output logic [COLS-1:0]          col_pins,
  output logic [$clog2(ROWS)-1:0]  row_idx,
  output logic                     frame_start
);

  localparam int RW = $clog2(ROWS);
  localparam logic RAL = (ROW_ACTIVE_LOW != 0);
  localparam logic CAL = (COL_ACTIVE_LOW != 0);
  localparam logic [3:0] BC_LAST = 4'(BLANK_CYCLES - 1);
  localparam logic [BRIGHT_BITS-1:0] P_LAST = {BRIGHT_BITS{1'b1}};
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } state_t;

  state_t                  state_q, state_n;
  logic [RW-1:0]           row_q, row_n;
  logic [BRIGHT_BITS-1:0]  p_q, p_n;
  logic [3:0]              bc_q, bc_n;
  logic                    fs_n;
  logic [ROWS*COLS-1:0]    pix_q;
  logic [BRIGHT_BITS-1:0]  bri_q;
  logic [ROWS-1:0]         row_d;
  logic [COLS-1:0]         col_d;
  logic [COLS-1:0]         row_bits;

  // State, counters and shadow registers; shadows load entering frame_start
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      p_q     <= '0;
      bc_q    <= '0;
      pix_q   <= '0;
      bri_q   <= '0;
    end else begin
      state_q <= state_n;
      row_q   <= row_n;
      p_q     <= p_n;
      bc_q    <= bc_n;
      if (fs_n) begin
        pix_q <= pixels;
        bri_q <= brightness;
      end
    end
  end

  // Next-state, counter and frame-start decode
  always_comb begin
    state_n = state_q;
    row_n   = row_q;
    p_n     = p_q;
    bc_n    = bc_q;
    fs_n    = 1'b0;
    unique case (state_q)
      IDLE: begin
        row_n = '0;
        p_n   = '0;
        bc_n  = '0;
        if (enable) begin
          state_n = BLANK;
          fs_n    = 1'b1;
        end
      end
      BLANK: begin
        if (!enable) begin
          state_n = IDLE;
          row_n   = '0;
          p_n     = '0;
          bc_n    = '0;
        end else if (bc_q == BC_LAST) begin
          state_n = DRIVE;
          p_n     = '0;
        end else begin
          bc_n = bc_q + 4'd1;
        end
      end
      DRIVE: begin
        if (!enable) begin
          state_n = IDLE;
          row_n   = '0;
          p_n     = '0;
          bc_n    = '0;
        end else if (p_q == P_LAST) begin
          state_n = BLANK;
          bc_n    = '0;
          p_n     = '0;
          if (row_q == ROW_LAST) begin
            row_n = '0;
            fs_n  = 1'b1;
          end else begin
            row_n = row_q + RW'(1);
          end
        end else begin
          p_n = p_q + BRIGHT_BITS'(1);
        end
      end
      default: begin
        state_n = IDLE;
        row_n   = '0;
        p_n     = '0;
        bc_n    = '0;
      end
    endcase
  end

  // Pin levels for the coming cycle, decoded from next state and shadows
  always_comb begin
    row_d    = {ROWS{RAL}};
    col_d    = {COLS{CAL}};
    row_bits = pix_q[row_n*COLS +: COLS];
    for (int r = 0; r < ROWS; r++) begin
      row_d[r] = RAL ^ ((state_n == DRIVE) && (row_n == RW'(r)));
    end
    for (int c = 0; c < COLS; c++) begin
      col_d[c] = CAL ^ ((state_n == DRIVE) && row_bits[c] && (p_n < bri_q));
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      row_pins    <= {ROWS{RAL}};
      col_pins    <= {COLS{CAL}};
      frame_start <= 1'b0;
    end else begin
      row_pins    <= row_d;
      col_pins    <= col_d;
      frame_start <= fs_n;
    end
  end

  assign row_idx = row_q;

endmodule

// File: tb/tb_matrix_scan.sv
// Directed bench for matrix_scan: default build plus an 8x3 active-polarity
// variant, checked against hand-computed pin patterns.
module tb_matrix_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pixels;
  logic [2:0]  brightness;
  logic        enable;
  logic [3:0]  row_pins;
  logic [3:0]  col_pins;
  logic [1:0]  row_idx;
  logic        frame_start;

  logic        rst2;
  logic [23:0] pixels2;
  logic [1:0]  bright2;
  logic        en2;
  logic [7:0]  row_pins2;
  logic [2:0]  col_pins2;
  logic [2:0]  row_idx2;
  logic        fs2;

  int total = 0;
  int passed = 0;
  int cur;

  always #5 clk = ~clk;

  matrix_scan dut (
    .clk(clk), .rst(rst), .pixels(pixels),
    .brightness(brightness), .enable(enable),
    .row_pins(row_pins), .col_pins(col_pins),
    .row_idx(row_idx), .frame_start(frame_start)
  );

  matrix_scan #(
    .ROWS(8), .COLS(3), .BRIGHT_BITS(2), .BLANK_CYCLES(3),
    .ROW_ACTIVE_LOW(0), .COL_ACTIVE_LOW(1)
  ) dut2 (
    .clk(clk), .rst(rst2), .pixels(pixels2),
    .brightness(bright2), .enable(en2),
    .row_pins(row_pins2), .col_pins(col_pins2),
    .row_idx(row_idx2), .frame_start(fs2)
  );

  typedef struct {
    int         cyc;
    logic [3:0] rp;
    logic [3:0] cp;
    logic       fs;
    logic [1:0] ri;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int n);
    while (cur < n) begin
      step();
      cur++;
    end
  endtask

  task automatic do_reset(input logic [15:0] pix, input logic [2:0] bri);
    rst = 1'b1;
    enable = 1'b1;
    pixels = pix;
    brightness = bri;
    step();
    step();
    rst = 1'b0;
    cur = -1;
  endtask

  initial begin
    int fscnt;
    int fsbad;
    int colbad;

    vt[0]  = '{0,  4'b1111, 4'b0000, 1'b1, 2'd0};
    vt[1]  = '{1,  4'b1110, 4'b0001, 1'b0, 2'd0};
    vt[2]  = '{7,  4'b1110, 4'b0001, 1'b0, 2'd0};
    vt[3]  = '{8,  4'b1110, 4'b0000, 1'b0, 2'd0};
    vt[4]  = '{9,  4'b1111, 4'b0000, 1'b0, 2'd1};
    vt[5]  = '{10, 4'b1101, 4'b0010, 1'b0, 2'd1};
    vt[6]  = '{17, 4'b1101, 4'b0000, 1'b0, 2'd1};
    vt[7]  = '{18, 4'b1111, 4'b0000, 1'b0, 2'd2};
    vt[8]  = '{19, 4'b1011, 4'b0100, 1'b0, 2'd2};
    vt[9]  = '{27, 4'b1111, 4'b0000, 1'b0, 2'd3};
    vt[10] = '{28, 4'b0111, 4'b1000, 1'b0, 2'd3};
    vt[11] = '{35, 4'b0111, 4'b0000, 1'b0, 2'd3};
    vt[12] = '{36, 4'b1111, 4'b0000, 1'b1, 2'd0};
    vt[13] = '{37, 4'b1110, 4'b0001, 1'b0, 2'd0};

    rst2 = 1'b1;
    en2 = 1'b0;
    pixels2 = 24'hFFFFFF;
    bright2 = 2'd3;

    // reset with enable high: reset wins
    do_reset(16'h8421, 3'd7);
    rst = 1'b1;
    step();
    chk("rst_rows", row_pins, 4'b1111);
    chk("rst_cols", col_pins, 4'b0000);
    chk("rst_fs", frame_start, 1'b0);
    chk("rst_idx", row_idx, 2'd0);
    rst = 1'b0;
    cur = -1;

    // basic scan, table driven
    for (int i = 0; i < 14; i++) begin
      goto(vt[i].cyc);
      chk($sformatf("v%0d_rows", vt[i].cyc), row_pins, vt[i].rp);
      chk($sformatf("v%0d_cols", vt[i].cyc), col_pins, vt[i].cp);
      chk($sformatf("v%0d_fs", vt[i].cyc), frame_start, vt[i].fs);
      chk($sformatf("v%0d_idx", vt[i].cyc), row_idx, vt[i].ri);
    end

    // brightness 0: rows scan, columns dark
    do_reset(16'hFFFF, 3'd0);
    fscnt = 0;
    fsbad = 0;
    colbad = 0;
    while (cur < 72) begin
      step();
      cur++;
      if (col_pins !== 4'b0000) colbad++;
      if (frame_start === 1'b1) begin
        fscnt++;
        if (cur % 36 != 0) fsbad++;
      end
      if (cur == 28) chk("b0_row3", row_pins, 4'b0111);
    end
    chk("b0_cols", colbad, 0);
    chk("b0_fs_count", fscnt, 3);
    chk("b0_fs_pos", fsbad, 0);

    // pixel change mid-frame only shows next frame
    do_reset(16'hFFFF, 3'd7);
    goto(10);
    pixels = 16'h0000;
    goto(19);
    chk("shd_row2", col_pins, 4'b1111);
    goto(28);
    chk("shd_row3", col_pins, 4'b1111);
    goto(37);
    chk("shd_next", col_pins, 4'b0000);

    // drop enable in row 2 drive, then re-enable
    do_reset(16'h8421, 3'd7);
    goto(20);
    enable = 1'b0;
    goto(21);
    chk("dis_rows", row_pins, 4'b1111);
    chk("dis_cols", col_pins, 4'b0000);
    chk("dis_idx", row_idx, 2'd0);
    goto(23);
    chk("dis_hold_fs", frame_start, 1'b0);
    enable = 1'b1;
    goto(24);
    chk("ren_fs", frame_start, 1'b1);
    chk("ren_idx", row_idx, 2'd0);
    goto(25);
    chk("ren_rows", row_pins, 4'b1110);

    // one-cycle reset in row 3
    do_reset(16'h8421, 3'd7);
    goto(30);
    rst = 1'b1;
    goto(31);
    chk("mrst_rows", row_pins, 4'b1111);
    chk("mrst_cols", col_pins, 4'b0000);
    chk("mrst_idx", row_idx, 2'd0);
    rst = 1'b0;
    goto(32);
    chk("mrst_fs", frame_start, 1'b1);
    goto(33);
    chk("mrst_row0", row_pins, 4'b1110);

    // 8x3 variant: period 7, frame 56, active-high rows, active-low cols
    rst2 = 1'b1;
    en2 = 1'b1;
    step();
    chk("p2_rst_rows", row_pins2, 8'h00);
    chk("p2_rst_cols", col_pins2, 3'b111);
    rst2 = 1'b0;
    cur = -1;
    while (cur < 56) begin
      step();
      cur++;
      if (cur == 0) chk("p2_c0_fs", fs2, 1'b1);
      if (cur == 2) chk("p2_c2_rows", row_pins2, 8'h00);
      if (cur == 3) chk("p2_c3_rows", row_pins2, 8'h01);
      if (cur == 3) chk("p2_c3_cols", col_pins2, 3'b000);
      if (cur == 6) chk("p2_c6_cols", col_pins2, 3'b111);
      if (cur == 7) chk("p2_c7_idx", row_idx2, 3'd1);
      if (cur == 10) chk("p2_c10_rows", row_pins2, 8'h02);
      if (cur == 52) chk("p2_c52_rows", row_pins2, 8'h80);
      if (cur == 52) chk("p2_c52_idx", row_idx2, 3'd7);
      if (cur == 55) chk("p2_c55_fs", fs2, 1'b0);
      if (cur == 56) chk("p2_c56_fs", fs2, 1'b1);
      if (cur == 56) chk("p2_c56_idx", row_idx2, 3'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
